// File: rtl/vproc_pkg.sv
// Shared constants and types for the vector coprocessor's VRF access path.
package vproc_pkg;

  localparam int unsigned VRF_ADDR_W       = 8;
  localparam int unsigned VRF_DATA_W       = 32;
  localparam logic [31:0] VRF_BASE_ADDR    = 32'h3000_0000;
  localparam int unsigned VRF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WB_RESP = 2'd1,
    ST_WB_ACK  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vrf_starve_ctr.sv
// Saturating wait counter: counts cycles a Wishbone request is passed over,
// flags saturation once the limit is reached.
module vrf_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign o_sat = (r_cnt == CW'(LIMIT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vrf_port_arbiter.sv
// Shares the single-port VRF SRAM between the Wishbone slave and the vector
// unit. VU wins by default; a starvation counter forces Wishbone through.
module vrf_port_arbiter
  import vproc_pkg::*;
#(
  parameter int unsigned DATA_W       = VRF_DATA_W,
  parameter int unsigned ADDR_W       = VRF_ADDR_W,
  parameter logic [31:0] BASE_ADDR    = VRF_BASE_ADDR,
  parameter int unsigned STARVE_LIMIT = VRF_STARVE_LIMIT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              vu_req_i,
  input  logic              vu_we_i,
  input  logic [ADDR_W-1:0] vu_addr_i,
  input  logic [DATA_W-1:0] vu_wdata_i,
  output logic              vu_gnt_o,
  output logic              vu_rvalid_o,
  output logic [DATA_W-1:0] vu_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              w_wb_hit;
  logic [ADDR_W-1:0] w_wb_addr;
  logic              w_wb_sel;
  logic              w_vu_sel;
  logic              w_sat;
  logic              w_starve_inc;
  logic              w_unused;
  logic              r_wb_we;
  logic              r_ack;
  logic [DATA_W-1:0] r_wb_rdata;
  logic              r_vu_rd_pend;
  logic              r_vu_rvalid;
  logic [DATA_W-1:0] r_vu_rdata;

  assign w_wb_hit  = wbs_cyc_i & wbs_stb_i &
                     (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign w_wb_addr = wbs_adr_i[ADDR_W+1:2];
  assign w_unused  = ^wbs_adr_i[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_wb_sel    = 1'b0;
    w_vu_sel    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sat && w_wb_hit) begin
          w_wb_sel = 1'b1;
        end else if (vu_req_i) begin
          w_vu_sel = 1'b1;
        end else if (w_wb_hit) begin
          w_wb_sel = 1'b1;
        end
        if (w_wb_sel) begin
          w_state_nxt = ST_WB_RESP;
        end
      end
      ST_WB_RESP: w_state_nxt = ST_WB_ACK;
      // The master still holds stb here; only the VU may use the port.
      ST_WB_ACK: begin
        w_vu_sel    = vu_req_i;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Grants are combinational, so hold them off while reset is asserted.
    if (!wb_rst_ni) begin
      w_wb_sel = 1'b0;
      w_vu_sel = 1'b0;
    end
  end

  assign w_starve_inc = (r_state == ST_IDLE) & w_wb_hit & ~w_wb_sel;

  vrf_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk  (wb_clk_i),
    .i_rst_n(wb_rst_ni),
    .i_inc  (w_starve_inc),
    .i_clr  (w_wb_sel),
    .o_sat  (w_sat)
  );

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (w_wb_sel) begin
      mem_en_o    = 1'b1;
      mem_we_o    = wbs_we_i;
      mem_addr_o  = w_wb_addr;
      mem_wdata_o = wbs_dat_i;
      mem_wmask_o = wbs_we_i ? wbs_sel_i : 4'h0;
    end else if (w_vu_sel) begin
      mem_en_o    = 1'b1;
      mem_we_o    = vu_we_i;
      mem_addr_o  = vu_addr_i;
      mem_wdata_o = vu_wdata_i;
      mem_wmask_o = 4'hF;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= ST_IDLE;
      r_wb_we    <= 1'b0;
      r_ack      <= 1'b0;
      r_wb_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (r_state == ST_WB_RESP);
      if (w_wb_sel) begin
        r_wb_we <= wbs_we_i;
      end
      if ((r_state == ST_WB_RESP) && !r_wb_we) begin
        r_wb_rdata <= mem_rdata_i;
      end
    end
  end

  // VU read return: SRAM data arrives one cycle after grant, registered once more.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_vu_rd_pend <= 1'b0;
      r_vu_rvalid  <= 1'b0;
      r_vu_rdata   <= '0;
    end else begin
      r_vu_rd_pend <= w_vu_sel & ~vu_we_i;
      r_vu_rvalid  <= r_vu_rd_pend;
      if (r_vu_rd_pend) begin
        r_vu_rdata <= mem_rdata_i;
      end
    end
  end

  assign vu_gnt_o    = w_vu_sel;
  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_wb_rdata;
  assign vu_rvalid_o = r_vu_rvalid;
  assign vu_rdata_o  = r_vu_rdata;

endmodule

// File: tb/tb_vrf_port_arbiter.sv
// Directed and randomized checks of vrf_port_arbiter against a cycle-level
// reference model and a behavioural SRAM.
module tb_vrf_port_arbiter;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          LIMIT = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        vu_req_i, vu_we_i;
  logic [7:0]  vu_addr_i;
  logic [31:0] vu_wdata_i;
  logic        vu_gnt_o, vu_rvalid_o;
  logic [31:0] vu_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_rdata_i;

  vrf_port_arbiter dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .vu_req_i   (vu_req_i),
    .vu_we_i    (vu_we_i),
    .vu_addr_i  (vu_addr_i),
    .vu_wdata_i (vu_wdata_i),
    .vu_gnt_o   (vu_gnt_o),
    .vu_rvalid_o(vu_rvalid_o),
    .vu_rdata_o (vu_rdata_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Behavioural VRF macro: byte-masked writes, registered reads.
  logic [31:0] sram [256];
  bit          sram_ready = 1'b0;
  always @(posedge wb_clk_i) begin
    if (!sram_ready) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'hC0DE_0000 + i;
      sram_ready <= 1'b1;
    end else if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] exp_wbdat;

  typedef struct {int due; logic [31:0] data;} rd_t;
  rd_t rdq[$];
  int  cyc_n;

  // reference-model state for the random phase
  bit          m_act;
  int          m_age;
  int          m_wait;
  logic [31:0] m_adr, m_dat, m_exp_rd;
  logic [3:0]  m_sel;
  bit          m_we;

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One WB transfer with VU idle: grant now, ack two cycles later.
  task automatic wb_direct(input string tag, input logic [31:0] adr, input bit we,
                           input logic [3:0] sel, input logic [31:0] dat,
                           output logic [31:0] rd);
    logic [7:0]  a;
    logic [31:0] exp_rd;
    a = adr[9:2];
    exp_rd = ref_mem[a];
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = dat; vu_req_i = 0;
    #1;
    chkb({tag, ".en"}, mem_en_o, 1'b1);
    chkb({tag, ".we"}, mem_we_o, we);
    chkw({tag, ".addr"}, 32'(mem_addr_o), 32'(a));
    chkb({tag, ".ack0"}, wbs_ack_o, 1'b0);
    if (we) begin
      chkw({tag, ".mask"}, 32'(mem_wmask_o), 32'(sel));
      chkw({tag, ".wdata"}, mem_wdata_o, dat);
      ref_mem[a] = merge(ref_mem[a], dat, sel);
    end
    @(negedge wb_clk_i); #1;
    chkb({tag, ".ack1"}, wbs_ack_o, 1'b0);
    chkb({tag, ".en1"}, mem_en_o, 1'b0);
    @(negedge wb_clk_i); #1;
    chkb({tag, ".ack2"}, wbs_ack_o, 1'b1);
    if (!we) exp_wbdat = exp_rd;
    chkw({tag, ".dat"}, wbs_dat_o, exp_wbdat);
    rd = wbs_dat_o;
    @(negedge wb_clk_i);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    #1;
    chkb({tag, ".ack3"}, wbs_ack_o, 1'b0);
  endtask

  // One random cycle checked against the arbitration/latency rules.
  task automatic rand_cycle();
    bit exp_wg, exp_vg, exp_ack, exp_rv;
    logic [7:0] a;
    @(negedge wb_clk_i);
    cyc_n++;
    if (!m_act && $urandom_range(0, 2) == 0) begin
      m_act  = 1;
      m_we   = $urandom_range(0, 1) == 1;
      m_sel  = 4'($urandom_range(0, 15));
      m_dat  = $urandom;
      m_adr  = BASE + {22'd0, 8'($urandom_range(0, 15)), 2'd0};
      m_wait = 0;
    end
    wbs_cyc_i = m_act; wbs_stb_i = m_act; wbs_we_i = m_we;
    wbs_sel_i = m_sel; wbs_adr_i = m_adr; wbs_dat_i = m_dat;
    vu_req_i   = $urandom_range(0, 3) != 0;
    vu_we_i    = $urandom_range(0, 3) == 0;
    vu_addr_i  = 8'($urandom_range(0, 15));
    vu_wdata_i = $urandom;
    #1;
    exp_ack = (m_age == 2);
    if (m_age == 1) begin
      exp_wg = 0; exp_vg = 0;
    end else if (m_age == 2) begin
      exp_wg = 0; exp_vg = vu_req_i;
    end else begin
      exp_wg = m_act && (m_wait >= LIMIT || !vu_req_i);
      exp_vg = vu_req_i && !exp_wg;
    end
    chkb("rnd.vgnt", vu_gnt_o, exp_vg);
    chkb("rnd.ack", wbs_ack_o, exp_ack);
    chkb("rnd.en", mem_en_o, exp_wg | exp_vg);
    if (exp_ack) begin
      if (!m_we) exp_wbdat = m_exp_rd;
      chkw("rnd.wbdat", wbs_dat_o, exp_wbdat);
    end
    if (exp_wg) begin
      a = m_adr[9:2];
      chkb("rnd.wb_we", mem_we_o, m_we);
      chkw("rnd.wb_addr", 32'(mem_addr_o), 32'(a));
      if (m_we) begin
        chkw("rnd.wb_mask", 32'(mem_wmask_o), 32'(m_sel));
        chkw("rnd.wb_wdata", mem_wdata_o, m_dat);
        ref_mem[a] = merge(ref_mem[a], m_dat, m_sel);
      end else begin
        m_exp_rd = ref_mem[a];
      end
    end
    if (exp_vg) begin
      chkb("rnd.vu_we", mem_we_o, vu_we_i);
      chkw("rnd.vu_addr", 32'(mem_addr_o), 32'(vu_addr_i));
      chkw("rnd.vu_mask", 32'(mem_wmask_o), 32'hF);
      if (vu_we_i) begin
        chkw("rnd.vu_wdata", mem_wdata_o, vu_wdata_i);
        ref_mem[vu_addr_i] = vu_wdata_i;
      end else begin
        rdq.push_back('{due: cyc_n + 2, data: ref_mem[vu_addr_i]});
      end
    end
    exp_rv = (rdq.size() > 0) && (rdq[0].due == cyc_n);
    chkb("rnd.rvalid", vu_rvalid_o, exp_rv);
    if (exp_rv) begin
      chkw("rnd.rdata", vu_rdata_o, rdq[0].data);
      void'(rdq.pop_front());
    end
    if (m_act && m_age < 0 && !exp_wg) m_wait++;
    if (exp_wg)          m_age = 1;
    else if (m_age == 1) m_age = 2;
    else if (m_age == 2) begin
      m_age = -1;
      m_act = 0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  va;
    bit          ghist [16];
    logic [7:0]  gaddr [16];
    bit          exp_vg;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + i;
    exp_wbdat = '0;
    wb_rst_ni = 0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = '0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    vu_req_i = 1; vu_we_i = 0; vu_addr_i = '0; vu_wdata_i = '0;

    // reset state, with a VU request held to show grants are suppressed
    @(negedge wb_clk_i); #1;
    chkb("rst.ack", wbs_ack_o, 1'b0);
    chkw("rst.wbdat", wbs_dat_o, 32'h0);
    chkb("rst.rvalid", vu_rvalid_o, 1'b0);
    chkw("rst.rdata", vu_rdata_o, 32'h0);
    chkb("rst.vgnt", vu_gnt_o, 1'b0);
    chkb("rst.en", mem_en_o, 1'b0);
    vu_req_i = 0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1;

    wb_direct("wr_full", BASE + 32'h10, 1, 4'hF, 32'hDEAD_BEEF, rd);
    wb_direct("rd_full", BASE + 32'h10, 0, 4'hF, 32'h0, rd);
    chkw("rd_full.value", rd, 32'hDEAD_BEEF);
    wb_direct("wr_part", BASE + 32'h10, 1, 4'b0011, 32'h1234_5678, rd);
    wb_direct("rd_part", BASE + 32'h10, 0, 4'hF, 32'h0, rd);
    chkw("rd_part.value", rd, 32'hDEAD_5678);

    // VU streams reads 0..9 while a WB read of word 4 waits for starvation
    va = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge wb_clk_i);
      if (c == 1) begin
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF;
        wbs_adr_i = BASE + 32'h10;
      end
      if (c == 8) begin
        wbs_cyc_i = 0; wbs_stb_i = 0;
      end
      vu_req_i = (va < 10); vu_we_i = 0; vu_addr_i = va;
      #1;
      exp_vg = (va < 10) && (c != 5) && (c != 6);
      chkb($sformatf("starve.vgnt%0d", c), vu_gnt_o, exp_vg);
      chkb($sformatf("starve.ack%0d", c), wbs_ack_o, c == 7);
      if (c == 1) chkw("simul.vu_wins_addr", 32'(mem_addr_o), 32'h0);
      if (c == 5) begin
        chkb("starve.wb_en", mem_en_o, 1'b1);
        chkb("starve.wb_we", mem_we_o, 1'b0);
        chkw("starve.wb_addr", 32'(mem_addr_o), 32'h4);
      end
      if (c == 6) chkb("starve.resp_idle", mem_en_o, 1'b0);
      if (c == 7) begin
        chkw("starve.wbdat", wbs_dat_o, 32'hDEAD_5678);
        exp_wbdat = 32'hDEAD_5678;
      end
      if (c >= 3) begin
        chkb($sformatf("starve.rvalid%0d", c), vu_rvalid_o, ghist[c-2]);
        if (ghist[c-2]) chkw($sformatf("starve.rdata%0d", c), vu_rdata_o, ref_mem[gaddr[c-2]]);
      end
      ghist[c] = exp_vg;
      gaddr[c] = va;
      if (exp_vg) va++;
    end
    vu_req_i = 0;

    // window miss: never reaches the SRAM, never acked
    for (int c = 0; c < 5; c++) begin
      @(negedge wb_clk_i);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h3100_0000;
      #1;
      chkb($sformatf("miss.en%0d", c), mem_en_o, 1'b0);
      chkb($sformatf("miss.ack%0d", c), wbs_ack_o, 1'b0);
    end
    @(negedge wb_clk_i);
    wbs_cyc_i = 0; wbs_stb_i = 0;

    // reset asserted while the WB read sits in its response cycle
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h10;
    #1;
    chkb("rstmid.grant", mem_en_o, 1'b1);
    @(negedge wb_clk_i); #1;
    wb_rst_ni = 0; vu_req_i = 1;
    #1;
    chkb("rstmid.ack", wbs_ack_o, 1'b0);
    chkw("rstmid.wbdat", wbs_dat_o, 32'h0);
    chkb("rstmid.vgnt", vu_gnt_o, 1'b0);
    chkb("rstmid.en", mem_en_o, 1'b0);
    chkb("rstmid.rvalid", vu_rvalid_o, 1'b0);
    chkw("rstmid.rdata", vu_rdata_o, 32'h0);
    exp_wbdat = '0;
    @(negedge wb_clk_i); #1;
    chkb("rstmid.no_ack", wbs_ack_o, 1'b0);
    wb_rst_ni = 1; vu_req_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
    wb_direct("post_rst", BASE + 32'h10, 0, 4'hF, 32'h0, rd);
    chkw("post_rst.value", rd, 32'hDEAD_5678);

    // randomized mix
    m_act = 0; m_age = -1; m_wait = 0; cyc_n = 0;
    m_adr = BASE; m_dat = '0; m_sel = '0; m_we = 0; m_exp_rd = '0;
    for (int i = 0; i < 400; i++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vrf_port_arbiter.md
# vrf_port_arbiter

Arbitrates the single-port vector register file (VRF) SRAM of the vector coprocessor between the Caravel management core (Wishbone slave port) and the vector execution unit (VU). The VU has priority by default; a starvation counter guarantees Wishbone progress. It sits in the user project wrapper between the Wishbone bus, the VU load/store path and the VRF macro.

## Interface
- DATA_W, 32: VRF word width; also the Wishbone data width.
- ADDR_W, 8: VRF word-address width (256 words).
- BASE_ADDR, 32'h3000_0000: Wishbone base of the VRF window.
- STARVE_LIMIT, 4: cycles a Wishbone request may wait before it beats the VU.
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_ni  in  1  reset; asynchronous, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte lane enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- vu_req_i, vu_we_i  in  1 each  VU access request and write flag.
- vu_addr_i  in  ADDR_W  VU word address.
- vu_wdata_i  in  DATA_W  VU write data (full-word writes only).
- vu_gnt_o  out  1  VU request accepted this cycle.
- vu_rvalid_o  out  1  VU read data valid.
- vu_rdata_o  out  DATA_W  VU read data.
- mem_en_o, mem_we_o  out  1 each  VRF access strobe and write enable.
- mem_addr_o  out  ADDR_W  VRF word address.
- mem_wdata_o  out  DATA_W  VRF write data.
- mem_wmask_o  out  4  VRF byte write mask.
- mem_rdata_i  in  DATA_W  VRF read data, valid one cycle after mem_en_o.

## Operation
- WB hit: wbs_cyc_i & wbs_stb_i & wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]; word address wbs_adr_i[ADDR_W+1:2]. Misses are ignored (never acked).
- FSM states IDLE, WB_RESP, WB_ACK.
- IDLE: if starve_cnt == STARVE_LIMIT and WB hit -> grant WB; else if vu_req_i -> grant VU; else if WB hit -> grant WB. WB grant drives mem port, goes to WB_RESP.
- WB_RESP: capture mem_rdata_i into wbs_dat_o (reads only; writes leave wbs_dat_o unchanged); register ack; go to WB_ACK. VU is not granted in this state.
- WB_ACK: wbs_ack_o high; WB hit ignored (master's stb still high); VU may be granted; go to IDLE.
- VU grant: vu_gnt_o combinational, mem port driven the same cycle; mem_wmask_o = 4'hF.
- WB writes: mem_wmask_o = wbs_sel_i.
- starve_cnt: increments, saturating at STARVE_LIMIT, in each cycle a WB hit is present in IDLE but not granted; clears on WB grant.
- Idle mem port: mem_en_o = 0, mem_we_o = 0; address/data don't-care.

## Timing
- Reset (async, any state): state IDLE, starve_cnt 0, wbs_ack_o 0, wbs_dat_o 0, vu_rvalid_o 0, vu_rdata_o 0; vu_gnt_o and mem_en_o low. Interrupted WB cycle is never acked.
- WB latency: grant cycle N, ack in cycle N+2, single-cycle ack pulse; identical for read and write.
- VU read: grant N, vu_rvalid_o/vu_rdata_o registered, valid in cycle N+2 for one cycle (pipelined, one per cycle).
- VU back-to-back throughput: one access per cycle while WB not starved.
- Simultaneous VU req and WB hit with starve_cnt < STARVE_LIMIT: VU wins.
- Worst-case WB wait: STARVE_LIMIT cycles from first hit in IDLE to grant.

## Structure
- Package vproc_pkg: arbiter state enum, VRF_ADDR_W/DATA_W constants, default BASE_ADDR.
- Sub-module vrf_starve_ctr: saturating counter with inc, clr, sat outputs.

## Test plan
- WB write 32'hDEAD_BEEF to 32'h3000_0010, sel 4'hF, VU idle -> mem_addr_o 4, mem_we_o 1, ack two cycles after grant; readback returns 32'hDEAD_BEEF.
- WB write sel 4'b0011 data 32'h1234_5678 -> mem_wmask_o 4'b0011; readback after prior 32'hDEAD_BEEF gives 32'hDEAD_5678.
- VU continuous reads addr 0..9 while WB read pending -> VU granted 4 cycles, WB granted cycle 5, ack cycle 7; VU resumes in WB_ACK.
- Simultaneous VU and WB request with starve_cnt 0 -> vu_gnt_o 1, WB ungranted that cycle.
- Access to 32'h3100_0000 -> no mem_en_o, no ack.
- wb_rst_ni low in WB_RESP -> all outputs zero immediately, no ack, next WB hit served normally.
